// File: rtl/data_memory_ws.sv
// Word-organised data memory with byte/half/word access, registered loads,
// programmable wait states and fault reporting for misaligned/out-of-range accesses.
module data_memory_ws #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter bit INIT_FIB    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        rdata_valid,
  output logic        stall,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] read_data_q, read_data_d;
  logic        rdata_valid_q, fault_q;
  logic        commit;

  // Power-up image only; contents survive rst_n.
  logic [31:0] mem_q [DEPTH] = '{1: (INIT_FIB ? 32'd1 : 32'd0), default: 32'd0};

  logic          req, is_store, is_load;
  logic [AW-1:0] word_idx;
  logic          out_range, misalign, bad;
  logic [31:0]   cur_word, store_word, load_val;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  assign req       = MemRead | MemWrite;
  assign is_store  = MemWrite;
  assign is_load   = MemRead & ~MemWrite;
  assign word_idx  = addr[AW+1:2];
  assign out_range = (addr[31:2] >= 30'(DEPTH));
  assign cur_word  = mem_q[word_idx];
  assign bad       = misalign | out_range;

  always_comb begin
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      read_data_q   <= 32'd0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      read_data_q   <= read_data_d;
      rdata_valid_q <= commit & is_load;
      fault_q       <= commit & bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && is_store && !bad) begin
      mem_q[word_idx] <= store_word;
    end
  end

  // Next-state; commit marks the edge that enters DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_DONE;
            commit  = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_BUSY: begin
        if (!req) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = req && (state_q != S_DONE);
    read_data   = read_data_q;
    rdata_valid = rdata_valid_q;
    fault       = fault_q;
  end

  always_comb begin
    store_word = cur_word;
    case (size)
      2'b00:   store_word[{addr[1:0], 3'b000} +: 8] = write_data[7:0];
      2'b01:   store_word[{addr[1], 4'b0000} +: 16] = write_data[15:0];
      default: store_word = write_data;
    endcase
  end

  always_comb begin
    byte_v = cur_word[{addr[1:0], 3'b000} +: 8];
    half_v = cur_word[{addr[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_val = unsigned_ld ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_val = unsigned_ld ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_val = cur_word;
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    if (commit && is_load) begin
      read_data_d = bad ? 32'd0 : load_val;
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_data_memory_ws;

  logic clk;
  logic [1:0]       rst_n, mem_read, mem_write, uns_ld;
  logic [1:0]       rdata_valid, stall, fault;
  logic [1:0][1:0]  size;
  logic [1:0][31:0] addr, wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_ws #(.DEPTH(64), .WAIT_STATES(0), .INIT_FIB(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .size(size[0]), .unsigned_ld(uns_ld[0]), .addr(addr[0]), .write_data(wdata[0]),
    .read_data(rdata[0]), .rdata_valid(rdata_valid[0]), .stall(stall[0]), .fault(fault[0])
  );

  data_memory_ws #(.DEPTH(64), .WAIT_STATES(3), .INIT_FIB(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .size(size[1]), .unsigned_ld(uns_ld[1]), .addr(addr[1]), .write_data(wdata[1]),
    .read_data(rdata[1]), .rdata_valid(rdata_valid[1]), .stall(stall[1]), .fault(fault[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Runs one access to completion; returns stall cycle count and the DONE-cycle outputs.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic us, input logic [31:0] a, input logic [31:0] wd,
                        output int n_stall, output logic [31:0] rdv, output logic rv,
                        output logic flt);
    mem_read[d]  = rd;
    mem_write[d] = wr;
    size[d]      = sz;
    uns_ld[d]    = us;
    addr[d]      = a;
    wdata[d]     = wd;
    n_stall      = 0;
    #1;
    while (stall[d] && n_stall < 40) begin
      n_stall++;
      @(negedge clk);
    end
    rdv = rdata[d];
    rv  = rdata_valid[d];
    flt = fault[d];
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(input string tag, input int d, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic us, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_rv, input logic exp_flt);
    int n;
    logic [31:0] rdv;
    logic rv, flt;
    access(d, rd, wr, sz, us, a, wd, n, rdv, rv, flt);
    chk({tag, "/stall_cycles"}, n, (d == 0) ? 32'd1 : 32'd4);
    chk({tag, "/read_data"}, rdv, exp_rd);
    chk({tag, "/rdata_valid"}, {31'd0, rv}, {31'd0, exp_rv});
    chk({tag, "/fault"}, {31'd0, flt}, {31'd0, exp_flt});
  endtask

  initial begin
    rst_n = 2'b00; mem_read = '0; mem_write = '0; uns_ld = '0;
    size = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d/read_data", d), rdata[d], 32'd0);
      chk($sformatf("reset%0d/rdata_valid", d), {31'd0, rdata_valid[d]}, 32'd0);
      chk($sformatf("reset%0d/fault", d), {31'd0, fault[d]}, 32'd0);
      chk($sformatf("reset%0d/stall", d), {31'd0, stall[d]}, 32'd0);
    end
    rst_n = 2'b11;
    @(negedge clk);

    // ---------------- zero wait states ----------------
    xfer("lw4",     0, 1, 0, 2'b10, 0, 32'd4,   32'd0,        32'h0000_0001, 1, 0);
    xfer("sb9",     0, 0, 1, 2'b00, 0, 32'd9,   32'h1234_5680, 32'h0000_0001, 0, 0);
    chk("sb9/mem2", u_dut0.mem_q[2], 32'h0000_8000);
    xfer("lb9",     0, 1, 0, 2'b00, 0, 32'd9,   32'd0,        32'hFFFF_FF80, 1, 0);
    xfer("lbu9",    0, 1, 0, 2'b00, 1, 32'd9,   32'd0,        32'h0000_0080, 1, 0);
    xfer("lw8",     0, 1, 0, 2'b10, 0, 32'd8,   32'd0,        32'h0000_8000, 1, 0);
    xfer("sh14",    0, 0, 1, 2'b01, 0, 32'd14,  32'hABCD_1234, 32'h0000_8000, 0, 0);
    xfer("lw12",    0, 1, 0, 2'b10, 0, 32'd12,  32'd0,        32'h1234_0000, 1, 0);
    xfer("lh13",    0, 1, 0, 2'b01, 0, 32'd13,  32'd0,        32'h0000_0000, 1, 1);
    chk("lh13/mem3", u_dut0.mem_q[3], 32'h1234_0000);
    xfer("sw16",    0, 0, 1, 2'b10, 0, 32'd16,  32'h0000_0055, 32'h0000_0000, 0, 0);
    xfer("sh18",    0, 0, 1, 2'b01, 0, 32'd18,  32'h0000_8001, 32'h0000_0000, 0, 0);
    xfer("lw16",    0, 1, 0, 2'b10, 0, 32'd16,  32'd0,        32'h8001_0055, 1, 0);
    xfer("lh18",    0, 1, 0, 2'b01, 0, 32'd18,  32'd0,        32'hFFFF_8001, 1, 0);
    xfer("lhu18",   0, 1, 0, 2'b01, 1, 32'd18,  32'd0,        32'h0000_8001, 1, 0);
    xfer("lb19",    0, 1, 0, 2'b00, 0, 32'd19,  32'd0,        32'hFFFF_FF80, 1, 0);
    xfer("lbu17",   0, 1, 0, 2'b00, 1, 32'd17,  32'd0,        32'h0000_0000, 1, 0);
    xfer("lh16",    0, 1, 0, 2'b01, 0, 32'd16,  32'd0,        32'h0000_0055, 1, 0);
    xfer("sw256",   0, 0, 1, 2'b10, 0, 32'd256, 32'hCAFE_F00D, 32'h0000_0055, 0, 1);
    chk("sw256/mem0", u_dut0.mem_q[0], 32'h0000_0000);
    chk("sw256/mem1", u_dut0.mem_q[1], 32'h0000_0001);
    xfer("lw2",     0, 1, 0, 2'b10, 0, 32'd2,   32'd0,        32'h0000_0000, 1, 1);
    xfer("lw4b",    0, 1, 0, 2'b10, 0, 32'd4,   32'd0,        32'h0000_0001, 1, 0);
    xfer("lw256",   0, 1, 0, 2'b10, 0, 32'd256, 32'd0,        32'h0000_0000, 1, 1);
    xfer("rdwr24",  0, 1, 1, 2'b10, 0, 32'd24,  32'h0000_0077, 32'h0000_0000, 0, 0);
    chk("rdwr24/mem6", u_dut0.mem_q[6], 32'h0000_0077);
    xfer("lrsv24",  0, 1, 0, 2'b11, 0, 32'd24,  32'd0,        32'h0000_0077, 1, 0);

    // ---------------- three wait states ----------------
    xfer("ws_lw4",  1, 1, 0, 2'b10, 0, 32'd4,   32'd0,        32'h0000_0001, 1, 0);

    mem_write[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'd20; wdata[1] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("ws_sw20/stall%0d", k), {31'd0, stall[1]}, 32'd1);
      chk($sformatf("ws_sw20/mem5_pre%0d", k), u_dut1.mem_q[5], 32'd0);
      @(negedge clk);
    end
    chk("ws_sw20/stall_done", {31'd0, stall[1]}, 32'd0);
    chk("ws_sw20/mem5_post", u_dut1.mem_q[5], 32'hDEAD_BEEF);
    chk("ws_sw20/rdata_valid", {31'd0, rdata_valid[1]}, 32'd0);
    mem_write[1] = 1'b0;
    @(negedge clk);
    xfer("ws_lw20", 1, 1, 0, 2'b10, 0, 32'd20,  32'd0,        32'hDEAD_BEEF, 1, 0);

    mem_write[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'd28; wdata[1] = 32'h1111_1111;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0; mem_write[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy/stall", {31'd0, stall[1]}, 32'd0);
    chk("rst_busy/read_data", rdata[1], 32'd0);
    chk("rst_busy/mem7", u_dut1.mem_q[7], 32'd0);
    chk("rst_busy/mem5_kept", u_dut1.mem_q[5], 32'hDEAD_BEEF);
    rst_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy/mem7_after", u_dut1.mem_q[7], 32'd0);
    chk("rst_busy/state_idle", {30'd0, u_dut1.state_q}, 32'd0);

    mem_write[1] = 1'b1; size[1] = 2'b10; addr[1] = 32'd32; wdata[1] = 32'h0000_0022;
    repeat (2) @(negedge clk);
    mem_write[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort/fault%0d", k), {31'd0, fault[1]}, 32'd0);
    end
    chk("abort/stall", {31'd0, stall[1]}, 32'd0);
    chk("abort/mem8", u_dut1.mem_q[8], 32'd0);
    xfer("ws_lw32", 1, 1, 0, 2'b10, 0, 32'd32,  32'd0,        32'h0000_0000, 1, 0);
    xfer("ws_lw256",1, 1, 0, 2'b10, 0, 32'd256, 32'd0,        32'h0000_0000, 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
